// File: rtl/mem_responder.sv
// mem_responder: word-addressed 16-bit data memory with a request/busy/ready
// handshake and a fixed, parameterised access latency.
//
// Build option: define MEM_ALIGN_CHECK_EN to flag odd byte addresses with
// MemErr. A flagged access runs the full latency but neither writes the array
// nor updates MemData. Without the macro, Addr[0] is ignored and MemErr is 0.
module mem_responder #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 2
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        MemReq,
    input  logic        MemWrite,
    input  logic [15:0] Addr,
    input  logic [15:0] WriteData,
    output logic [15:0] MemData,
    output logic        MemBusy,
    output logic        MemReady,
    output logic        MemErr
);

    if (LATENCY < 1 || LATENCY > 15) begin : gBadLatency
        $error("mem_responder: LATENCY must be in the range 1..15");
    end

    localparam int unsigned DEPTH   = 1 << ADDR_W;
    localparam logic [3:0]  cntInit = 4'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} stateT;

    stateT              state;
    logic [3:0]         count;
    logic [ADDR_W-1:0]  latAddr;
    logic               latWrite;
    logic [15:0]        latData;
    logic               busyQ;
    logic               readyQ;
    logic               errQ;
    logic               misaligned;
    logic               accessNow;
    logic               memWe;
    logic               unusedAddr;

    logic [15:0]        mem [DEPTH];

    // Upper address bits alias; bit 0 is only meaningful with the align check.
    assign unusedAddr = ^Addr;

`ifdef MEM_ALIGN_CHECK_EN
    logic latOdd;

    // Capture the byte-offset bit of each accepted request.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            latOdd <= 1'b0;
        end else if (state == StIdle && MemReq) begin
            latOdd <= Addr[0];
        end
    end

    assign misaligned = latOdd;
`else
    assign misaligned = 1'b0;
`endif

    // The access happens on the edge where the WAIT countdown has expired.
    assign accessNow = (state == StWait) && (count == 4'd0);
    assign memWe     = accessNow && latWrite && !misaligned;

    // Storage array: written only on the access edge of a store, never reset.
    always_ff @(posedge CLK) begin
        if (memWe) begin
            mem[latAddr] <= latData;
        end
    end

    // Handshake FSM with registered outputs; reset discards any pending access.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state    <= StIdle;
            count    <= 4'd0;
            latAddr  <= '0;
            latWrite <= 1'b0;
            latData  <= 16'h0000;
            MemData  <= 16'h0000;
            busyQ    <= 1'b0;
            readyQ   <= 1'b0;
            errQ     <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    readyQ <= 1'b0;
                    errQ   <= 1'b0;
                    if (MemReq) begin
                        latAddr  <= Addr[ADDR_W:1];
                        latWrite <= MemWrite;
                        latData  <= WriteData;
                        count    <= cntInit;
                        busyQ    <= 1'b1;
                        state    <= StWait;
                    end else begin
                        busyQ <= 1'b0;
                    end
                end
                StWait: begin
                    if (count != 4'd0) begin
                        count <= count - 4'd1;
                    end else begin
                        // Stores and flagged accesses leave MemData untouched.
                        if (!latWrite && !misaligned) begin
                            MemData <= mem[latAddr];
                        end
                        readyQ <= 1'b1;
                        errQ   <= misaligned;
                        state  <= StResp;
                    end
                end
                StResp: begin
                    busyQ  <= 1'b0;
                    readyQ <= 1'b0;
                    errQ   <= 1'b0;
                    state  <= StIdle;
                end
                default: begin
                    busyQ  <= 1'b0;
                    readyQ <= 1'b0;
                    errQ   <= 1'b0;
                    state  <= StIdle;
                end
            endcase
        end
    end

    assign MemBusy  = busyQ;
    assign MemReady = readyQ;
    assign MemErr   = errQ;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (ADDR_W = 10, LATENCY = 2).
module tb_mem_responder;

    localparam int unsigned LAT = 2;

    logic        CLK;
    logic        reset;
    logic        MemReq;
    logic        MemWrite;
    logic [15:0] Addr;
    logic [15:0] WriteData;
    logic [15:0] MemData;
    logic        MemBusy;
    logic        MemReady;
    logic        MemErr;

    int errors = 0;
    int checks = 0;

    mem_responder #(
        .ADDR_W (10),
        .LATENCY(LAT)
    ) dut (
        .CLK      (CLK),
        .reset    (reset),
        .MemReq   (MemReq),
        .MemWrite (MemWrite),
        .Addr     (Addr),
        .WriteData(WriteData),
        .MemData  (MemData),
        .MemBusy  (MemBusy),
        .MemReady (MemReady),
        .MemErr   (MemErr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete request: accept, wait for the ready pulse, return to idle.
    task automatic doReq(input string tag, input logic wr, input logic [15:0] adr,
                         input logic [15:0] wdata, input logic [15:0] expData,
                         input logic expErr);
        int n;
        MemReq    = 1'b1;
        MemWrite  = wr;
        Addr      = adr;
        WriteData = wdata;
        tick();
        MemReq = 1'b0;
        check({tag, " busy after accept"}, 32'(MemBusy), 32'd1);
        check({tag, " no early ready"}, 32'(MemReady), 32'd0);
        n = 0;
        while (MemReady !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check({tag, " ready latency"}, 32'(n), 32'(LAT));
        check({tag, " data at ready"}, 32'(MemData), 32'(expData));
        check({tag, " err at ready"}, 32'(MemErr), 32'(expErr));
        check({tag, " busy in resp"}, 32'(MemBusy), 32'd1);
        tick();
        check({tag, " ready one cycle"}, 32'(MemReady), 32'd0);
        check({tag, " idle not busy"}, 32'(MemBusy), 32'd0);
        check({tag, " data held"}, 32'(MemData), 32'(expData));
    endtask

    initial begin
        logic [15:0] expOdd;
        logic        expOddErr;
        reset     = 1'b0;
        MemReq    = 1'b0;
        MemWrite  = 1'b0;
        Addr      = 16'h0000;
        WriteData = 16'h0000;
        tick();
        tick();
        check("reset MemData", 32'(MemData), 32'h0);
        check("reset MemBusy", 32'(MemBusy), 32'd0);
        check("reset MemReady", 32'(MemReady), 32'd0);
        check("reset MemErr", 32'(MemErr), 32'd0);
        reset = 1'b1;
        tick();

        // Store then load, MemData untouched by the store.
        doReq("st BEEF@0010", 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0);
        doReq("ld 0010", 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0);

        // A store leaves the last load result on MemData.
        doReq("st 1234@0020", 1'b1, 16'h0020, 16'h1234, 16'hBEEF, 1'b0);
        doReq("ld 0020", 1'b0, 16'h0020, 16'h0000, 16'h1234, 1'b0);

        // 0x0804 and 0x0004 both map to word 2.
        doReq("st A5A5@0804", 1'b1, 16'h0804, 16'hA5A5, 16'h1234, 1'b0);
        doReq("ld 0004 wrap", 1'b0, 16'h0004, 16'h0000, 16'hA5A5, 1'b0);

        // Held request: two back-to-back loads with MemReq never dropped.
        MemReq   = 1'b1;
        MemWrite = 1'b0;
        Addr     = 16'h0010;
        tick();
        check("held acc1 busy", 32'(MemBusy), 32'd1);
        Addr = 16'h0020;
        tick();
        check("held wait1 busy", 32'(MemBusy), 32'd1);
        check("held wait1 ready", 32'(MemReady), 32'd0);
        tick();
        check("held resp1 ready", 32'(MemReady), 32'd1);
        check("held resp1 data", 32'(MemData), 32'hBEEF);
        tick();
        check("held idle busy", 32'(MemBusy), 32'd0);
        check("held idle ready", 32'(MemReady), 32'd0);
        tick();
        check("held acc2 busy", 32'(MemBusy), 32'd1);
        MemReq = 1'b0;
        tick();
        check("held wait2 ready", 32'(MemReady), 32'd0);
        tick();
        check("held resp2 ready", 32'(MemReady), 32'd1);
        check("held resp2 data", 32'(MemData), 32'h1234);
        tick();
        check("held end busy", 32'(MemBusy), 32'd0);
        check("held end ready", 32'(MemReady), 32'd0);

        // Reset while a store sits in WAIT: outputs clear and the write is lost.
        MemReq    = 1'b1;
        MemWrite  = 1'b1;
        Addr      = 16'h0010;
        WriteData = 16'hDEAD;
        tick();
        MemReq = 1'b0;
        check("pre-reset busy", 32'(MemBusy), 32'd1);
        reset = 1'b0;
        #1;
        check("mid-reset MemData", 32'(MemData), 32'h0);
        check("mid-reset MemBusy", 32'(MemBusy), 32'd0);
        check("mid-reset MemReady", 32'(MemReady), 32'd0);
        tick();
        tick();
        tick();
        check("reset held MemBusy", 32'(MemBusy), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("post-reset no ready", 32'(MemReady), 32'd0);
            check("post-reset not busy", 32'(MemBusy), 32'd0);
        end
        doReq("ld 0010 after abort", 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0);

        // Odd address: flagged and dropped with the check, else it writes word 8.
`ifdef MEM_ALIGN_CHECK_EN
        expOdd    = 16'hBEEF;
        expOddErr = 1'b1;
`else
        expOdd    = 16'h7777;
        expOddErr = 1'b0;
`endif
        doReq("st 7777@0011", 1'b1, 16'h0011, 16'h7777, 16'hBEEF, expOddErr);
        doReq("ld 0010 after odd", 1'b0, 16'h0010, 16'h0000, expOdd, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
